hnf_rx_link_chan: RTL and testbench

//  Generic CHI link-layer receive channel for the HN-F (REQ/DAT/RSP instances).
//  - Runs the RX link-activation handshake and issues L-credits bounded by buffer space.
//  - Buffers received flits in an order-preserving queue; presents them to HN-F pipeline by valid/ready.
//  - Flags protocol and TgtID errors as sticky outputs.

---
 rtl/hnf_rx_link_chan_pkg.sv | 22 ++
 rtl/hnf_rx_link_chan_sfifo.sv | 71 +++++++
 rtl/hnf_rx_link_chan.sv | 155 +++++++++++++++
 tb/tb_hnf_rx_link_chan.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hnf_rx_link_chan_pkg.sv
// Shared link-layer types and constants for the HN-F receive link channels.
//  link_state_e : RX link-activation state (STOP, ACT, RUN, DEACT)
//  CHI_MAX_LCRD : architectural ceiling on outstanding L-credits
//  CHI_LINK_OPC : Opcode value that marks an L-credit return (link) flit
//  min_u        : elaboration-time minimum helper
package hnf_rx_link_chan_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ACT   = 2'd1,
        RUN   = 2'd2,
        DEACT = 2'd3
    } link_state_e;

    localparam int unsigned CHI_MAX_LCRD = 15;
    localparam int unsigned CHI_LINK_OPC = 0;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/hnf_rx_link_chan_sfifo.sv
// Synchronous FIFO with first-word view: rdata always shows the head entry.
//  clock, reset : clock and synchronous active-high reset
//  wr_en, wdata : push request and data (ignored when full)
//  rd_en        : pop request (ignored when empty)
//  rdata        : head-of-queue data, valid while !empty
//  count        : current occupancy
//  full, empty  : occupancy flags derived from count
module hnf_rx_link_chan_sfifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr_c;
    logic             do_rd_c;

    // Pointer wrap handles non power-of-two depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr_c = wr_en && !full;
    assign do_rd_c = rd_en && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array, no reset needed: entries are only read once written.
    always_ff @(posedge clock) begin
        if (do_wr_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr_c, do_rd_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hnf_rx_link_chan.sv
// CHI link-layer receive channel for the HN-F (REQ/DAT/RSP instances).
// Runs the RX link-activation handshake, grants L-credits bounded by buffer
// space, queues received flits in order and flags protocol/TgtID errors.
//  clock, reset       : clock and synchronous active-high reset
//  rx_flit/flitv      : incoming flit and its valid
//  rx_flitpend        : flit pending, one cycle ahead of flitv
//  rx_lcrdv           : registered L-credit grant pulse
//  rx_linkactivereq   : transmitter link-activate request
//  rx_linkactiveack   : registered link-activate acknowledge
//  deq_flit/valid/ready : head-of-queue handshake towards the HN-F pipeline
//  crd_out            : outstanding credits held by the transmitter
//  q_count            : queue occupancy
//  proto_err, tgt_err : sticky error flags, cleared only by reset
module hnf_rx_link_chan
    import hnf_rx_link_chan_pkg::*;
#(
    parameter int unsigned FLIT_W  = 128,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAX_CRD = 15,
    parameter int unsigned OPC_LSB = 0,
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned TGT_LSB = 4,
    parameter int unsigned TGT_W   = 7,
    parameter int unsigned MY_ID   = 0,
    parameter int unsigned CHK_TGT = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [FLIT_W-1:0]            rx_flit,
    input  logic                         rx_flitv,
    input  logic                         rx_flitpend,
    output logic                         rx_lcrdv,
    input  logic                         rx_linkactivereq,
    output logic                         rx_linkactiveack,
    output logic [FLIT_W-1:0]            deq_flit,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [$clog2(MAX_CRD+1)-1:0] crd_out,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         proto_err,
    output logic                         tgt_err
);

    localparam int unsigned CRD_W   = $clog2(MAX_CRD + 1);
    localparam int unsigned Q_W     = $clog2(DEPTH + 1);
    localparam int unsigned CRD_LIM = min_u(min_u(MAX_CRD, DEPTH), CHI_MAX_LCRD);
    localparam int unsigned SUM_W   = ((CRD_W > Q_W) ? CRD_W : Q_W) + 1;

    link_state_e      state;
    logic             pend_q;
    logic [OPC_W-1:0] opc_c;
    logic [TGT_W-1:0] tgt_c;
    logic [SUM_W-1:0] occ_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             is_link_c;
    logic             accept_c;
    logic             no_crd_c;
    logic             push_c;
    logic             overflow_c;
    logic             pop_c;
    logic             grant_c;

    assign opc_c     = rx_flit[OPC_LSB +: OPC_W];
    assign tgt_c     = rx_flit[TGT_LSB +: TGT_W];
    assign is_link_c = (opc_c == OPC_W'(CHI_LINK_OPC));

    // Every accepted flit consumes a credit; only protocol flits take a slot.
    assign accept_c   = rx_flitv && (crd_out != '0);
    assign no_crd_c   = rx_flitv && (crd_out == '0);
    assign push_c     = accept_c && !is_link_c && !fifo_full;
    assign overflow_c = accept_c && !is_link_c && fifo_full;
    assign pop_c      = deq_valid && deq_ready;

    // Credits in flight plus queued flits never exceed the buffer.
    assign occ_c   = SUM_W'(crd_out) + SUM_W'(q_count);
    assign grant_c = (state == RUN)
                  && (crd_out < CRD_W'(CRD_LIM))
                  && (occ_c < SUM_W'(DEPTH));

    assign deq_valid = !fifo_empty;

    // Link FSM, credit counter, pend register and sticky errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= STOP;
            rx_linkactiveack <= 1'b0;
            rx_lcrdv         <= 1'b0;
            crd_out          <= '0;
            pend_q           <= 1'b0;
            proto_err        <= 1'b0;
            tgt_err          <= 1'b0;
        end else begin
            pend_q   <= rx_flitpend;
            rx_lcrdv <= grant_c;

            case ({grant_c, accept_c})
                2'b10:   crd_out <= crd_out + CRD_W'(1);
                2'b01:   crd_out <= crd_out - CRD_W'(1);
                default: crd_out <= crd_out;
            endcase

            if ((rx_flitv && !pend_q) || no_crd_c || overflow_c) begin
                proto_err <= 1'b1;
            end
            if (push_c && (CHK_TGT != 0) && (tgt_c != TGT_W'(MY_ID))) begin
                tgt_err <= 1'b1;
            end

            case (state)
                STOP: begin
                    if (rx_linkactivereq) begin
                        state            <= ACT;
                        rx_linkactiveack <= 1'b1;
                    end
                end
                ACT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!rx_linkactivereq) begin
                        state <= DEACT;
                    end
                end
                DEACT: begin
                    // Wait for the transmitter to hand back every credit.
                    if (crd_out == '0) begin
                        state            <= STOP;
                        rx_linkactiveack <= 1'b0;
                    end
                end
                default: begin
                    state            <= STOP;
                    rx_linkactiveack <= 1'b0;
                end
            endcase
        end
    end

    hnf_rx_link_chan_sfifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (push_c),
        .wdata (rx_flit),
        .rd_en (pop_c),
        .rdata (deq_flit),
        .count (q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_hnf_rx_link_chan.sv
// Self-checking bench for hnf_rx_link_chan: a cycle reference model of the
// link rules plus a flit scoreboard checked by an independent monitor.
module tb_hnf_rx_link_chan;

    localparam int unsigned FLIT_W = 128;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned MAXC   = 15;
    localparam int unsigned MY_ID  = 0;
    localparam int          LIM    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [FLIT_W-1:0] rx_flit;
    logic              rx_flitv;
    logic              rx_flitpend;
    logic              rx_lcrdv;
    logic              rx_linkactivereq;
    logic              rx_linkactiveack;
    logic [FLIT_W-1:0] deq_flit;
    logic              deq_valid;
    logic              deq_ready;
    logic [3:0]        crd_out;
    logic [3:0]        q_count;
    logic              proto_err;
    logic              tgt_err;

    always #5 clock = ~clock;

    hnf_rx_link_chan #(
        .FLIT_W (FLIT_W), .DEPTH (DEPTH), .MAX_CRD (MAXC), .OPC_LSB (0), .OPC_W (6),
        .TGT_LSB (4), .TGT_W (7), .MY_ID (MY_ID), .CHK_TGT (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_flit          (rx_flit),
        .rx_flitv         (rx_flitv),
        .rx_flitpend      (rx_flitpend),
        .rx_lcrdv         (rx_lcrdv),
        .rx_linkactivereq (rx_linkactivereq),
        .rx_linkactiveack (rx_linkactiveack),
        .deq_flit         (deq_flit),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .crd_out          (crd_out),
        .q_count          (q_count),
        .proto_err        (proto_err),
        .tgt_err          (tgt_err)
    );

    int errors = 0;
    int checks = 0;
    logic [FLIT_W-1:0] exp_q [$];
    int tx_crd = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (link-level rules) ----------------
    localparam int S_STOP = 0, S_ACT = 1, S_RUN = 2, S_DEACT = 3;
    int m_state = S_STOP, m_crd = 0, m_q = 0;
    bit m_ack = 0, m_lcrdv = 0, m_pend = 0, m_proto = 0, m_tgt = 0;
    // inputs as they were at the most recent rising edge
    bit p_reset = 1'b1, p_flitv = 1'b0, p_pend = 1'b0, p_ready = 1'b0, p_req = 1'b0;
    logic [FLIT_W-1:0] p_flit = '0;

    always @(negedge clock) begin : monitor
        int opc, tgt, old_crd;
        bit grant, acc, push, pop;
        logic [FLIT_W-1:0] head;
        if (p_reset) begin
            m_state = S_STOP; m_ack = 0; m_crd = 0; m_q = 0;
            m_lcrdv = 0; m_pend = 0; m_proto = 0; m_tgt = 0;
        end else begin
            opc     = int'(p_flit[5:0]);
            tgt     = int'(p_flit[10:4]);
            old_crd = m_crd;
            grant   = (m_state == S_RUN) && (m_crd < LIM) && (m_crd + m_q < DEPTH);
            acc     = p_flitv && (m_crd > 0);
            push    = acc && (opc != 0) && (m_q < DEPTH);
            pop     = p_ready && (m_q > 0);
            if (p_flitv && (!m_pend || m_crd == 0)) m_proto = 1;
            if (acc && opc != 0 && m_q == DEPTH) m_proto = 1;
            if (push && tgt != MY_ID) m_tgt = 1;
            m_crd   = m_crd + int'(grant) - int'(acc);
            m_q     = m_q + int'(push) - int'(pop);
            m_lcrdv = grant;
            m_pend  = p_pend;
            case (m_state)
                S_STOP:  if (p_req) begin m_state = S_ACT; m_ack = 1; end
                S_ACT:   m_state = S_RUN;
                S_RUN:   if (!p_req) m_state = S_DEACT;
                default: if (old_crd == 0) begin m_state = S_STOP; m_ack = 0; end
            endcase
        end
        check("lcrdv", longint'(rx_lcrdv), longint'(m_lcrdv));
        check("ack", longint'(rx_linkactiveack), longint'(m_ack));
        check("crd_out", longint'(crd_out), longint'(m_crd));
        check("q_count", longint'(q_count), longint'(m_q));
        check("deq_valid", longint'(deq_valid), longint'(m_q > 0));
        check("proto_err", longint'(proto_err), longint'(m_proto));
        check("tgt_err", longint'(tgt_err), longint'(m_tgt));
        // scoreboard: a pop happens at the next edge
        if (!reset && deq_ready && m_q > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got %h expected nothing", deq_flit);
            end else begin
                head = exp_q.pop_front();
                if (deq_flit !== head) begin
                    errors++;
                    $display("FAIL deq_flit: got %h expected %h", deq_flit, head);
                end
            end
        end
        p_reset = reset; p_flitv = rx_flitv; p_pend = rx_flitpend;
        p_ready = deq_ready; p_req = rx_linkactivereq; p_flit = rx_flit;
    end

    // ---------------- stimulus (transmitter side) ----------------
    function automatic logic [FLIT_W-1:0] make_flit(input bit is_link, input logic [6:0] tgt);
        logic [FLIT_W-1:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        f[10:4] = tgt;
        f[3:0]  = 4'($urandom_range(1, 15));
        if (is_link) f[5:0] = '0;
        return f;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (rx_lcrdv === 1'b1) tx_crd++;
    endtask

    // Sends one flit if a credit is held; data flits go to the scoreboard.
    task automatic cycle(input bit send, input bit is_link, input logic [6:0] tgt);
        rx_flitv = 1'b0;
        if (send && tx_crd > 0) begin
            rx_flit  = make_flit(is_link, tgt);
            rx_flitv = 1'b1;
            tx_crd--;
            if (!is_link) exp_q.push_back(rx_flit);
        end
        tick();
        rx_flitv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'(MY_ID));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        deq_ready = 1'b0;
        rx_flitv  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        tx_crd = 0;
        reset  = 1'b0;
    endtask

    task automatic wait_crd(input string name, input int target, input int budget);
        for (int i = 0; i < budget && tx_crd != target; i++) idle(1);
        check(name, longint'(tx_crd), longint'(target));
    endtask

    initial begin
        reset = 1'b1; rx_flit = '0; rx_flitv = 1'b0; rx_flitpend = 1'b1;
        rx_linkactivereq = 1'b1; deq_ready = 1'b0;

        // 1: activation from reset and initial credit burst
        tick(); tick(); tick();
        check("t1_ack_in_reset", longint'(rx_linkactiveack), 0);
        reset = 1'b0;
        tick();
        check("t1_ack_cycle1", longint'(rx_linkactiveack), 1);
        idle(12);
        check("t1_grants", longint'(tx_crd), 8);
        check("t1_crd_out", longint'(crd_out), 8);

        // 2: fill the queue, then free one slot
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 7'(MY_ID));
        idle(3);
        check("t2_q_full", longint'(q_count), 8);
        check("t2_crd_zero", longint'(crd_out), 0);
        deq_ready = 1'b1;
        idle(1);
        deq_ready = 1'b0;
        wait_crd("t2_regrant", 1, 6);

        // 3: steady stream, then randomized traffic and back-pressure
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 7'(MY_ID));
        for (int i = 0; i < 80; i++) begin
            deq_ready = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 7'(MY_ID));
        end
        deq_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(12);
        check("t3_drained", longint'(exp_q.size()), 0);
        check("t3_crd_refill", longint'(crd_out), 8);

        // 4: deactivate with 3 credits out, returned by link flits
        deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 7'(MY_ID));
        idle(3);
        check("t4_crd3", longint'(crd_out), 3);
        rx_linkactivereq = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 7'(MY_ID));
        for (int i = 0; i < 6 && rx_linkactiveack; i++) idle(1);
        check("t4_ack_low", longint'(rx_linkactiveack), 0);
        check("t4_q_kept", longint'(q_count), 5);
        deq_ready = 1'b1;
        idle(8);
        check("t4_drained", longint'(exp_q.size()), 0);

        // 5: flit without credit, then flit without pend
        rx_flit  = make_flit(1'b0, 7'(MY_ID));
        rx_flitv = 1'b1;
        tick();
        rx_flitv = 1'b0;
        idle(1);
        check("t5_nocrd_err", longint'(proto_err), 1);
        check("t5_nocrd_drop", longint'(q_count), 0);
        do_reset();
        check("t5_err_cleared", longint'(proto_err), 0);
        rx_linkactivereq = 1'b1;
        idle(12);
        rx_flitpend = 1'b0;
        idle(1);
        cycle(1'b1, 1'b0, 7'(MY_ID));
        rx_flitpend = 1'b1;
        idle(2);
        check("t5_nopend_err", longint'(proto_err), 1);
        check("t5_nopend_kept", longint'(q_count), 1);
        deq_ready = 1'b1;
        idle(3);

        // 6: TgtID mismatch, then reset with a populated queue
        do_reset();
        idle(12);
        cycle(1'b1, 1'b0, 7'(MY_ID + 1));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 7'(MY_ID));
        idle(2);
        check("t6_tgt_err", longint'(tgt_err), 1);
        check("t6_q4", longint'(q_count), 4);
        do_reset();
        check("t6_q_reset", longint'(q_count), 0);
        check("t6_crd_reset", longint'(crd_out), 0);
        check("t6_valid_reset", longint'(deq_valid), 0);
        check("t6_tgt_reset", longint'(tgt_err), 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
